// File: rtl/counter_readout_ctrl.sv
// counter_readout_ctrl
//   Dumps a bank of FIFO pop counters as a stream of 8-bit words. On a start
//   request while the system is idle, each counter 0..NUM_CNT-1 is read once
//   from the counter block and emitted as {index, count}. The downstream side
//   can stall with hold. A read that never returns within TIMEOUT cycles
//   aborts the dump and sets a sticky error flag.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   reset      synchronous active-low reset
//   start      dump request (level sampled, honoured only in IDLE)
//   idle_in    system idle indication, gates the start of a dump
//   hold       downstream stall, 1 = current word not accepted
//   cnt_data   counter value returned for cnt_idx
//   cnt_valid  counter block read-valid, same cycle as cnt_req
//   cnt_req    read request to the counter block
//   cnt_idx    counter index being read
//   out_data   {cnt_idx, captured count}
//   out_valid  out_data is valid
//   out_last   current word belongs to the last counter
//   busy       dump in progress
//   done       one-cycle pulse at the end of a dump (normal or aborted)
//   err        sticky timeout flag, cleared when the next dump starts
module counter_readout_ctrl #(
  parameter int NUM_CNT = 5,
  parameter int TIMEOUT = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       idle_in,
  input  logic       hold,
  input  logic [4:0] cnt_data,
  input  logic       cnt_valid,
  output logic       cnt_req,
  output logic [2:0] cnt_idx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]    LAST_IDX = 3'(NUM_CNT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [4:0]    cap, cap_nxt;
  logic          err_q, err_nxt;

  // State register. The reset is sampled on the clock edge only.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      tcnt  <= '0;
      cap   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tcnt  <= tcnt_nxt;
      cap   <= cap_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tcnt_nxt  = tcnt;
    cap_nxt   = cap;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (start && idle_in) begin
          state_nxt = S_REQ;
          idx_nxt   = '0;
          tcnt_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end
      S_REQ: begin
        if (cnt_valid) begin
          // Snapshot taken here; later counter movement cannot reach out_data.
          cap_nxt   = cnt_data;
          state_nxt = S_OUT;
        end else if (tcnt == TO_LAST) begin
          // This was the last allowed cycle without a response: abort.
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_OUT: begin
        if (!hold) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            tcnt_nxt  = '0;
            state_nxt = S_REQ;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, all zero outside REQ/OUT except done.
  always_comb begin
    cnt_req   = 1'b0;
    cnt_idx   = '0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_REQ: begin
        cnt_req = 1'b1;
        cnt_idx = idx;
        busy    = 1'b1;
      end
      S_OUT: begin
        cnt_idx   = idx;
        out_data  = {idx, cap};
        out_valid = 1'b1;
        out_last  = (idx == LAST_IDX);
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/counter_readout_ctrl.md
COUNTER_READOUT_CTRL -- requirements
Module: counter_readout_ctrl

Interface
REQ-001 Parameter NUM_CNT, default 5: number of FIFO pop counters scanned per dump, indices 0..NUM_CNT-1.
REQ-002 Parameter TIMEOUT, default 4: cycles in REQ without cnt_valid before abort.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  dump request; level-sampled.
REQ-006 idle_in  input  1  system IDLE indication; a dump may start only when 1.
REQ-007 hold  input  1  downstream stall; 1 = current output word not accepted.
REQ-008 cnt_data  input  5  counter value returned by the counter block for cnt_idx.
REQ-009 cnt_valid  input  1  counter block read-valid, same cycle as cnt_req.
REQ-010 cnt_req  output  1  read request to the counter block.
REQ-011 cnt_idx  output  3  counter index being read.
REQ-012 out_data  output  8  {cnt_idx[2:0], captured count[4:0]}.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_last  output  1  current word is index NUM_CNT-1.
REQ-015 busy  output  1  dump in progress; 1 in REQ and OUT.
REQ-016 done  output  1  one-cycle pulse at dump end, normal or aborted.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 FSM states: IDLE, REQ, OUT, DONE; registered state, Moore outputs except where stated.
REQ-019 IDLE: start=1 and idle_in=1 -> REQ, idx<=0, timeout count<=0, err<=0; otherwise stay in IDLE.
REQ-020 REQ: cnt_req=1 and cnt_idx=idx; cnt_valid=1 -> capture cnt_data into a 5-bit hold register, go to OUT.
REQ-021 REQ with cnt_valid=0: timeout count +1; when the count reaches TIMEOUT-1 with cnt_valid=0, set err<=1 and go to DONE, with no word output for that idx.
REQ-022 OUT: out_valid=1, out_data={idx, captured}, out_last=(idx==NUM_CNT-1); cnt_req=0.
REQ-023 OUT with hold=1: stay; out_data, out_valid and out_last stay stable.
REQ-024 OUT with hold=0: word accepted; if idx==NUM_CNT-1 -> DONE, else idx<=idx+1, timeout count<=0, -> REQ.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-026 start while busy or in DONE is ignored and not queued; start held high through DONE begins a new dump from IDLE on the following cycle if idle_in=1.
REQ-027 idle_in is checked only in IDLE; deassertion mid-dump does not abort the dump.
REQ-028 In IDLE and DONE: cnt_req=0, out_valid=0, out_last=0, out_data=0, cnt_idx=0.
REQ-029 Latency with hold=0 and cnt_valid=1: start at cycle t -> cnt_req at t+1 -> first out_valid at t+2; 2 cycles per counter; out_last at t+2*NUM_CNT; done at t+2*NUM_CNT+1.
REQ-030 idx never exceeds NUM_CNT-1; no wrap-around within a dump.
REQ-031 The captured value is the counter snapshot at the REQ cycle; counter changes during OUT do not alter out_data.

Reset
REQ-032 reset=0 at a posedge forces state=IDLE, idx=0, timeout count=0, captured=0, err=0; all outputs 0 the following cycle.
REQ-033 Reset mid-dump aborts the dump immediately, with no done pulse and no further out_valid.
REQ-034 After reset deasserts, the block accepts start on the first cycle.

Verification
REQ-035 Reset: hold reset=0 for 2 cycles with start=1 -> all outputs 0, busy=0.
REQ-036 Normal dump: counters 0..4 = 3,7,0,31,12, hold=0, start pulse with idle_in=1 at t -> out_data 0x03,0x27,0x40,0x7F,0x8C at t+2,t+4,t+6,t+8,t+10; out_last at t+10 only; done at t+11.
REQ-037 Backpressure: hold=1 for 3 cycles on idx 1 -> out_data 0x27 is stable for 4 cycles; dump completes 3 cycles late; no word is dropped or duplicated.
REQ-038 Timeout: cnt_valid tied 0 -> cnt_req high for 4 cycles, then err=1 and done pulse, no out_valid; err clears on the next accepted start.
REQ-039 Gating: start=1 with idle_in=0 -> no cnt_req; start re-pulsed during a dump -> exactly one dump of 5 words.
REQ-040 Reset mid-dump: reset=0 during OUT for idx 2 -> next cycle out_valid=0, busy=0, done=0; a new start yields idx 0 first.
